bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Registered multi-master bus controller for the SoC interconnect.
- Arbitrates three masters (m0 core load/store, m1 instruction fetch, m2 debug/loader) onto one shared slave port.
- Decodes the slave from the address (0 ROM, 1 RAM, 2 GPIO) and sequences each access through an IDLE/ACCESS/RESP state machine.
- Generates per-master ack/err and the core hold flag.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NUM_SLAVES, 3, number of decoded slaves; the slave index is addr[ADDR_W-1:ADDR_W-4]
- RD_LAT, 1, slave read latency in cycles (1..4); also the length of the ACCESS phase

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- m_req_i  in  3  per-master request; bit n = master n
- m_we_i  in  3  per-master write enable
- m_addr_i  in  3*ADDR_W  master n at [n*ADDR_W +: ADDR_W]
- m_wdata_i  in  3*DATA_W  master n at [n*DATA_W +: DATA_W]
- m_rdata_o  out  DATA_W  read data, shared; valid only while an ack bit is high
- m_ack_o  out  3  one-cycle completion pulse for the granted master
- m_err_o  out  3  one-cycle error pulse (unmapped address), coincident with ack
- s_sel_o  out  NUM_SLAVES  one-hot slave select
- s_addr_o  out  ADDR_W  latched address
- s_we_o  out  1  slave write strobe
- s_wdata_o  out  DATA_W  latched write data
- s_rdata_i  in  NUM_SLAVES*DATA_W  slave read data; slave k at [k*DATA_W +: DATA_W]
- grant_o  out  2  index of the current/last granted master
- hold_flag_o  out  1  pipeline stall to the core

Behaviour:
- Reset values: state IDLE; m_ack_o, m_err_o, s_sel_o, s_we_o = 0; s_addr_o, s_wdata_o = 0; grant_o = 2, so m0 has top priority on the first arbitration.
- IDLE:
  - If any m_req_i bit is set, choose the winner round-robin, searching from grant_o+1 mod 3.
  - On the clock edge: latch the winner's addr, we and wdata; latch slave index = addr[top 4 bits]; update grant_o; go to ACCESS.
  - If no request, stay in IDLE.
- ACCESS: lasts RD_LAT cycles, tracked by a 2-bit counter.
  - s_sel_o[idx] is high throughout, if idx < NUM_SLAVES.
  - s_we_o is high in the first ACCESS cycle only, and only if the latched we = 1. Writes are single-cycle and exactly one strobe per transaction.
  - Unmapped idx (>= NUM_SLAVES): s_sel_o stays all-zero and no write strobe is issued.
  - After RD_LAT cycles, go to RESP.
- RESP: one cycle.
  - m_ack_o[grant_o] = 1.
  - m_rdata_o = s_rdata_i[idx] for a mapped read; 0 for writes or unmapped accesses.
  - m_err_o[grant_o] = 1 if unmapped.
  - s_sel_o = 0.
  - Next state is always IDLE.
  - Slaves must hold their read data until the next select.
- Outside RESP: m_rdata_o = 0 and ack/err = 0.
- Latency (RD_LAT=1, no contention): req seen in cycle 0, ACCESS in cycle 1, ack in cycle 2. Throughput is one transaction per RD_LAT+2 cycles.
- Masters hold req/addr/we/wdata stable until ack. Changes after the grant edge are ignored, because the values are latched.
- Req dropped before ack: the latched transaction still completes and the ack still pulses (harmless). The master re-arbitrates normally afterwards.
- A master still requesting in the cycle after its ack is treated as a new request.
- hold_flag_o is combinational: (m_req_i & ~m_ack_o) != 0, i.e. some master is waiting and not being acked this cycle.
- Simultaneous requests are resolved purely by the round-robin pointer. Worst-case wait is 2 transactions of other masters.
- Reset mid-operation:
  - Immediately to IDLE; all outputs take their reset values on the next edge.
  - No ack is issued for the aborted transfer.
  - A write whose ACCESS cycle already passed a clock edge is committed.
- Address decode uses the top 4 bits only. Lower bits pass through unmodified; slaves do their own word indexing.

Test Plan:
- Single read, m1 fetch addr 0x0000_0004, ROM returns 0x0000_0093 (RD_LAT=1) -> s_sel_o=001 in cycle 1; m_ack_o=010 and m_rdata_o=0x0000_0093 in cycle 2; hold_flag_o=1 in cycles 0-1, 0 in cycle 2.
- Write then read, m0 write 0x1000_0010 = 0xDEAD_BEEF, then read the same address -> s_we_o pulses exactly once with s_sel_o=010; read ack returns 0xDEAD_BEEF.
- All three requesting continuously from reset -> grant sequence 0,1,2,0,1,2; each ack exactly 3 cycles apart; no master waits more than 2 transactions.
- Unmapped read at 0xF000_0000 by m2 -> s_sel_o stays 000, no s_we_o; in RESP m_ack_o=100, m_err_o=100, m_rdata_o=0.
- RD_LAT=3, m0 read from RAM -> s_sel_o high for 3 cycles; ack at cycle 4 after req; s_we_o never asserted.
- rst asserted during ACCESS of an m1 read -> next cycle state IDLE, all outputs zero, no ack for m1; after rst release m1 still requesting gets a fresh grant and completes normally.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Three-master, single-slave-port bus controller. Masters are picked
//   round-robin, the access is latched and sequenced through an
//   IDLE -> ACCESS -> RESP state machine, and the slave is decoded from the
//   top four address bits (0 ROM, 1 RAM, 2 GPIO).
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   m_req_i/m_we_i  per-master request and write enable (bit n = master n)
//   m_addr_i        master n address at [n*ADDR_W +: ADDR_W]
//   m_wdata_i       master n write data at [n*DATA_W +: DATA_W]
//   m_rdata_o       shared read data, non-zero only in the response cycle
//   m_ack_o/m_err_o one-cycle completion / unmapped-address pulses
//   s_sel_o         one-hot slave select during the access phase
//   s_addr_o        latched address, s_we_o write strobe, s_wdata_o write data
//   s_rdata_i       slave k read data at [k*DATA_W +: DATA_W]
//   grant_o         index of the current or most recently granted master
//   hold_flag_o     some master is requesting and not being acked
//
// RD_LAT must lie in 1..4; it sets the length of the ACCESS phase and is
// tracked by a 2-bit counter.
module bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 3,
  parameter int RD_LAT     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0]                   m_req_i,
  input  logic [2:0]                   m_we_i,
  input  logic [3*ADDR_W-1:0]          m_addr_i,
  input  logic [3*DATA_W-1:0]          m_wdata_i,
  output logic [DATA_W-1:0]            m_rdata_o,
  output logic [2:0]                   m_ack_o,
  output logic [2:0]                   m_err_o,
  output logic [NUM_SLAVES-1:0]        s_sel_o,
  output logic [ADDR_W-1:0]            s_addr_o,
  output logic                         s_we_o,
  output logic [DATA_W-1:0]            s_wdata_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata_i,
  output logic [1:0]                   grant_o,
  output logic                         hold_flag_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [3:0]          idx_q, idx_d;

  logic [1:0]          winner;
  logic                found;
  logic [1:0]          cand;
  logic                mapped;

  // Next master index modulo 3.
  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v >= 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  assign mapped = (int'(idx_q) < NUM_SLAVES);

  // Round-robin search starting one past the last grant, so the master that
  // was just served has the lowest priority next time.
  always_comb begin
    winner = grant_q;
    found  = 1'b0;
    cand   = inc3(grant_q);
    for (int i = 0; i < 3; i++) begin
      if (!found && m_req_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
      cand = inc3(cand);
    end
  end

  // Next-state logic: the winner's request is captured on the grant edge so
  // later changes on the master side cannot disturb the transaction.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          for (int k = 0; k < 3; k++) begin
            if (winner == 2'(k)) begin
              addr_d  = m_addr_i[k*ADDR_W +: ADDR_W];
              wdata_d = m_wdata_i[k*DATA_W +: DATA_W];
              we_d    = m_we_i[k];
              idx_d   = m_addr_i[k*ADDR_W + ADDR_W - 4 +: 4];
            end
          end
          grant_d = winner;
          cnt_d   = 2'd0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 2'(RD_LAT - 1)) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and transaction registers. grant resets to 2 so master 0 wins the
  // first arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= 2'd2;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
    end
  end

  // Bus-side outputs are decoded from the registered state. The write strobe
  // only fires on the first ACCESS cycle so a long ACCESS phase still gives
  // exactly one write.
  always_comb begin
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    m_ack_o   = 3'b000;
    m_err_o   = 3'b000;
    m_rdata_o = '0;
    case (state_q)
      ST_ACCESS: begin
        for (int k = 0; k < NUM_SLAVES; k++) begin
          if (mapped && int'(idx_q) == k) begin
            s_sel_o[k] = 1'b1;
          end
        end
        s_we_o = we_q && mapped && (cnt_q == 2'd0);
      end
      ST_RESP: begin
        m_ack_o = 3'b001 << grant_q;
        if (!mapped) begin
          m_err_o = 3'b001 << grant_q;
        end else if (!we_q) begin
          for (int k = 0; k < NUM_SLAVES; k++) begin
            if (int'(idx_q) == k) begin
              m_rdata_o = s_rdata_i[k*DATA_W +: DATA_W];
            end
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign s_addr_o    = addr_q;
  assign s_wdata_o   = wdata_q;
  assign grant_o     = grant_q;
  assign hold_flag_o = |(m_req_i & ~m_ack_o);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
//   Directed bench for bus_arbiter. Two instances share the master-side
//   stimulus: dut1 with RD_LAT=1 and dut3 with RD_LAT=3. Slave read data
//   comes from a small model: fixed ROM word, a one-word RAM written through
//   dut1's strobe, and a fixed GPIO word.
module tb_bus_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   m_req = 3'b000;
  logic [2:0]   m_we = 3'b000;
  logic [95:0]  m_addr = '0;
  logic [95:0]  m_wdata = '0;

  logic [31:0]  rdata1, rdata3;
  logic [2:0]   ack1, ack3, err1, err3, sel1, sel3;
  logic [31:0]  saddr1, saddr3, swdata1, swdata3;
  logic         swe1, swe3, hold1, hold3;
  logic [1:0]   grant1, grant3;
  logic [95:0]  srdata1, srdata3;

  localparam logic [31:0] ROM_WORD  = 32'h0000_0093;
  localparam logic [31:0] GPIO_WORD = 32'h0000_00AA;
  localparam logic [31:0] RAM3_WORD = 32'h1234_5678;

  logic [31:0]  ram_word = 32'h0;
  int           we_count1 = 0;
  int           we_count3 = 0;
  int           checks = 0;
  int           failures = 0;
  int           base;

  assign srdata1 = {GPIO_WORD, ram_word, ROM_WORD};
  assign srdata3 = {GPIO_WORD, RAM3_WORD, ROM_WORD};

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr),
    .m_wdata_i(m_wdata), .m_rdata_o(rdata1), .m_ack_o(ack1), .m_err_o(err1),
    .s_sel_o(sel1), .s_addr_o(saddr1), .s_we_o(swe1), .s_wdata_o(swdata1),
    .s_rdata_i(srdata1), .grant_o(grant1), .hold_flag_o(hold1)
  );

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr),
    .m_wdata_i(m_wdata), .m_rdata_o(rdata3), .m_ack_o(ack3), .m_err_o(err3),
    .s_sel_o(sel3), .s_addr_o(saddr3), .s_we_o(swe3), .s_wdata_o(swdata3),
    .s_rdata_i(srdata3), .grant_o(grant3), .hold_flag_o(hold3)
  );

  always #5 clk = ~clk;

  // RAM slave model and write-strobe counters.
  always @(posedge clk) begin
    if (swe1 && sel1[1]) ram_word <= swdata1;
    if (swe1) we_count1 <= we_count1 + 1;
    if (swe3) we_count3 <= we_count3 + 1;
  end

  // Watchdog so a broken run still terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int m, input logic req, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata);
    m_req[m]            = req;
    m_we[m]             = we;
    m_addr[m*32 +: 32]  = addr;
    m_wdata[m*32 +: 32] = wdata;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic doReset;
    rst   = 1'b1;
    m_req = 3'b000;
    m_we  = 3'b000;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    sample();
    checkOutput("rst_ack", {29'b0, ack1}, 32'h0);
    checkOutput("rst_err", {29'b0, err1}, 32'h0);
    checkOutput("rst_sel", {29'b0, sel1}, 32'h0);
    checkOutput("rst_we", {31'b0, swe1}, 32'h0);
    checkOutput("rst_addr", saddr1, 32'h0);
    checkOutput("rst_wdata", swdata1, 32'h0);
    checkOutput("rst_grant", {30'b0, grant1}, 32'd2);
  endtask

  initial begin
    int exp_m;
    logic [31:0] exp_d;

    // Single ROM read by m1.
    doReset();
    next_cycle();
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
    sample();
    checkOutput("t1_hold_c0", {31'b0, hold1}, 32'd1);
    checkOutput("t1_ack_c0", {29'b0, ack1}, 32'h0);
    next_cycle();
    sample();
    checkOutput("t1_sel_c1", {29'b0, sel1}, 32'b001);
    checkOutput("t1_addr_c1", saddr1, 32'h0000_0004);
    checkOutput("t1_hold_c1", {31'b0, hold1}, 32'd1);
    next_cycle();
    sample();
    checkOutput("t1_ack_c2", {29'b0, ack1}, 32'b010);
    checkOutput("t1_rdata_c2", rdata1, ROM_WORD);
    checkOutput("t1_hold_c2", {31'b0, hold1}, 32'd0);
    checkOutput("t1_sel_c2", {29'b0, sel1}, 32'h0);
    checkOutput("t1_grant", {30'b0, grant1}, 32'd1);
    next_cycle();
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // m0 writes RAM then reads the same address back.
    doReset();
    base = we_count1;
    next_cycle();
    applyStimulus(0, 1'b1, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF);
    next_cycle();
    sample();
    checkOutput("t2_we_c1", {31'b0, swe1}, 32'd1);
    checkOutput("t2_sel_c1", {29'b0, sel1}, 32'b010);
    checkOutput("t2_wdata_c1", swdata1, 32'hDEAD_BEEF);
    next_cycle();
    applyStimulus(0, 1'b1, 1'b0, 32'h1000_0010, 32'h0);
    sample();
    checkOutput("t2_ack_w", {29'b0, ack1}, 32'b001);
    checkOutput("t2_rdata_w", rdata1, 32'h0);
    checkOutput("t2_we_c2", {31'b0, swe1}, 32'd0);
    next_cycle();
    next_cycle();
    sample();
    checkOutput("t2_sel_rd", {29'b0, sel1}, 32'b010);
    checkOutput("t2_we_rd", {31'b0, swe1}, 32'd0);
    next_cycle();
    sample();
    checkOutput("t2_ack_r", {29'b0, ack1}, 32'b001);
    checkOutput("t2_rdata_r", rdata1, 32'hDEAD_BEEF);
    checkOutput("t2_we_count", 32'(we_count1 - base), 32'd1);
    next_cycle();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);

    // All three masters requesting continuously: grants rotate 0,1,2.
    doReset();
    next_cycle();
    applyStimulus(0, 1'b1, 1'b0, 32'h1000_0000, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
    applyStimulus(2, 1'b1, 1'b0, 32'h2000_0000, 32'h0);
    for (int t = 0; t < 6; t++) begin
      exp_m = t % 3;
      exp_d = (exp_m == 0) ? 32'hDEAD_BEEF : (exp_m == 1) ? ROM_WORD : GPIO_WORD;
      next_cycle();
      sample();
      checkOutput($sformatf("t3_ack_access_%0d", t), {29'b0, ack1}, 32'h0);
      next_cycle();
      sample();
      checkOutput($sformatf("t3_ack_%0d", t), {29'b0, ack1}, 32'(1 << exp_m));
      checkOutput($sformatf("t3_grant_%0d", t), {30'b0, grant1}, 32'(exp_m));
      checkOutput($sformatf("t3_rdata_%0d", t), rdata1, exp_d);
      next_cycle();
    end
    m_req = 3'b000;

    // Unmapped accesses by m2: read, then write.
    doReset();
    next_cycle();
    applyStimulus(2, 1'b1, 1'b0, 32'hF000_0000, 32'h0);
    next_cycle();
    sample();
    checkOutput("t4_sel", {29'b0, sel1}, 32'h0);
    checkOutput("t4_we", {31'b0, swe1}, 32'd0);
    next_cycle();
    sample();
    checkOutput("t4_ack", {29'b0, ack1}, 32'b100);
    checkOutput("t4_err", {29'b0, err1}, 32'b100);
    checkOutput("t4_rdata", rdata1, 32'h0);
    next_cycle();
    applyStimulus(2, 1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();
    applyStimulus(2, 1'b1, 1'b1, 32'hF000_0008, 32'h5555_AAAA);
    next_cycle();
    sample();
    checkOutput("t4w_sel", {29'b0, sel1}, 32'h0);
    checkOutput("t4w_we", {31'b0, swe1}, 32'd0);
    next_cycle();
    sample();
    checkOutput("t4w_err", {29'b0, err1}, 32'b100);
    next_cycle();
    applyStimulus(2, 1'b0, 1'b0, 32'h0, 32'h0);

    // RD_LAT=3 read from RAM by m0 on dut3.
    doReset();
    base = we_count3;
    next_cycle();
    applyStimulus(0, 1'b1, 1'b0, 32'h1000_0000, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      sample();
      checkOutput($sformatf("t5_sel_c%0d", c), {29'b0, sel3}, 32'b010);
      checkOutput($sformatf("t5_ack_c%0d", c), {29'b0, ack3}, 32'h0);
    end
    next_cycle();
    sample();
    checkOutput("t5_ack_c4", {29'b0, ack3}, 32'b001);
    checkOutput("t5_rdata_c4", rdata3, RAM3_WORD);
    checkOutput("t5_sel_c4", {29'b0, sel3}, 32'h0);
    checkOutput("t5_we_count", 32'(we_count3 - base), 32'd0);
    next_cycle();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset during the ACCESS phase of an m1 read.
    doReset();
    next_cycle();
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
    next_cycle();
    sample();
    checkOutput("t6_sel_c1", {29'b0, sel1}, 32'b001);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    sample();
    checkOutput("t6_ack_c2", {29'b0, ack1}, 32'h0);
    checkOutput("t6_sel_c2", {29'b0, sel1}, 32'h0);
    checkOutput("t6_grant_c2", {30'b0, grant1}, 32'd2);
    checkOutput("t6_addr_c2", saddr1, 32'h0);
    next_cycle();
    sample();
    checkOutput("t6_sel_c3", {29'b0, sel1}, 32'b001);
    checkOutput("t6_grant_c3", {30'b0, grant1}, 32'd1);
    next_cycle();
    sample();
    checkOutput("t6_ack_c4", {29'b0, ack1}, 32'b010);
    checkOutput("t6_rdata_c4", rdata1, ROM_WORD);
    next_cycle();
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
